// File: rtl/exception_ctrl.sv
// Exception/interrupt arbiter between MEM stage and CP0.
// Synchronizes external interrupt lines and bypasses pending WB-stage CP0
// writes into Status/Cause/EPC. Prioritizes interrupts over MEM exception
// flags, then drives the CP0 exception type, the pipeline flush and the
// restart PC. A small FSM masks interrupts while the pipeline refills.
module exception_ctrl #(
  parameter logic [31:0] EXCEPTION_VECTOR = 32'h0000_0020,
  parameter int          HOLD_CYCLES      = 2,
  parameter int          SYNC_STAGES      = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  interrupt_raw_input,
  input  logic        timer_interrupt_input,
  output logic [5:0]  interrupt_sync_output,
  input  logic [31:0] exception_flags_input,
  input  logic [31:0] current_instruction_address_input,
  input  logic [31:0] cp0_status_input,
  input  logic [31:0] cp0_cause_input,
  input  logic [31:0] cp0_epc_input,
  input  logic        wb_cp0_write_enable_input,
  input  logic [4:0]  wb_cp0_write_address_input,
  input  logic [31:0] wb_cp0_data_input,
  output logic [31:0] exception_type_output,
  output logic        flush_output,
  output logic [31:0] new_pc_output,
  output logic [31:0] epc_effective_output
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  localparam bit         HOLD_EN = (HOLD_CYCLES > 0);
  localparam logic [3:0] HOLD_LD = HOLD_CYCLES[3:0];

  localparam logic [4:0] ADDR_STATUS = 5'd12;
  localparam logic [4:0] ADDR_CAUSE  = 5'd13;
  localparam logic [4:0] ADDR_EPC    = 5'd14;

  logic [SYNC_STAGES-1:0][5:0] sync_q;
  logic [0:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] status_eff, cause_eff, epc_eff;
  logic        int_req;
  logic [31:0] exc_type;
  logic        flush;
  logic [31:0] new_pc;

  // Multi-flop synchronizer for the asynchronous interrupt lines.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= interrupt_raw_input;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Bypass the CP0 registers with a WB-stage write that has not landed yet.
  // Only the software-writable Cause bits (IP1:0, IV, WP) are forwarded.
  always_comb begin
    status_eff = cp0_status_input;
    cause_eff  = cp0_cause_input;
    epc_eff    = cp0_epc_input;
    if (wb_cp0_write_enable_input) begin
      if (wb_cp0_write_address_input == ADDR_STATUS) status_eff = wb_cp0_data_input;
      if (wb_cp0_write_address_input == ADDR_CAUSE) begin
        cause_eff[9:8] = wb_cp0_data_input[9:8];
        cause_eff[22]  = wb_cp0_data_input[22];
        cause_eff[23]  = wb_cp0_data_input[23];
      end
      if (wb_cp0_write_address_input == ADDR_EPC) epc_eff = wb_cp0_data_input;
    end
  end

  // Interrupts need IE=1, EXL=0, a real instruction and no refill hold.
  assign int_req = ((cause_eff[15:8] & status_eff[15:8]) != 8'h00) &&
                   status_eff[0] && !status_eff[1] &&
                   (current_instruction_address_input != 32'h0) &&
                   (state_q != HOLD);

  // Prioritize interrupt over synchronous flags; a bubble never excepts.
  always_comb begin
    exc_type = 32'h0;
    if (current_instruction_address_input != 32'h0) begin
      if (int_req)                        exc_type = 32'h1;
      else if (exception_flags_input[8])  exc_type = 32'h8;
      else if (exception_flags_input[9])  exc_type = 32'ha;
      else if (exception_flags_input[10]) exc_type = 32'hd;
      else if (exception_flags_input[11]) exc_type = 32'hc;
      else if (exception_flags_input[12]) exc_type = 32'he;
    end
  end

  assign flush  = (exc_type != 32'h0);
  assign new_pc = (exc_type == 32'he) ? epc_eff :
                  flush               ? EXCEPTION_VECTOR : 32'h0;

  // Outputs are held at zero while reset is asserted.
  always_comb begin
    interrupt_sync_output    = '0;
    exception_type_output    = '0;
    flush_output             = 1'b0;
    new_pc_output            = '0;
    epc_effective_output     = '0;
    if (!reset) begin
      interrupt_sync_output    = sync_q[SYNC_STAGES-1];
      interrupt_sync_output[5] = sync_q[SYNC_STAGES-1][5] | timer_interrupt_input;
      exception_type_output    = exc_type;
      flush_output             = flush;
      new_pc_output            = new_pc;
      epc_effective_output     = epc_eff;
    end
  end

  // Refill-hold FSM: any flush (re)arms the counter; leave when it hits 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (HOLD_EN) begin
      if (flush) begin
        state_d = HOLD;
        cnt_d   = HOLD_LD;
      end else if (state_q == HOLD) begin
        if (cnt_q <= 4'd1) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
    end
  end

  // FSM state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{status_eff[31:16], status_eff[7:2], cause_eff[31:16],
                         cause_eff[7:0], exception_flags_input[31:13],
                         exception_flags_input[7:0]};

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed testbench for exception_ctrl with default parameters
// (vector 0x20, two hold cycles, two synchronizer stages).
module tb_exception_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  interrupt_raw_input;
  logic        timer_interrupt_input;
  logic [5:0]  interrupt_sync_output;
  logic [31:0] exception_flags_input;
  logic [31:0] current_instruction_address_input;
  logic [31:0] cp0_status_input, cp0_cause_input, cp0_epc_input;
  logic        wb_cp0_write_enable_input;
  logic [4:0]  wb_cp0_write_address_input;
  logic [31:0] wb_cp0_data_input;
  logic [31:0] exception_type_output;
  logic        flush_output;
  logic [31:0] new_pc_output;
  logic [31:0] epc_effective_output;

  int errors = 0;
  int checks = 0;

  exception_ctrl dut (
    .clock                             (clock),
    .reset                             (reset),
    .interrupt_raw_input               (interrupt_raw_input),
    .timer_interrupt_input             (timer_interrupt_input),
    .interrupt_sync_output             (interrupt_sync_output),
    .exception_flags_input             (exception_flags_input),
    .current_instruction_address_input (current_instruction_address_input),
    .cp0_status_input                  (cp0_status_input),
    .cp0_cause_input                   (cp0_cause_input),
    .cp0_epc_input                     (cp0_epc_input),
    .wb_cp0_write_enable_input         (wb_cp0_write_enable_input),
    .wb_cp0_write_address_input        (wb_cp0_write_address_input),
    .wb_cp0_data_input                 (wb_cp0_data_input),
    .exception_type_output             (exception_type_output),
    .flush_output                      (flush_output),
    .new_pc_output                     (new_pc_output),
    .epc_effective_output              (epc_effective_output)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    interrupt_raw_input               = 6'h0;
    timer_interrupt_input             = 1'b0;
    exception_flags_input             = 32'h0;
    current_instruction_address_input = 32'h0;
    cp0_status_input                  = 32'h0;
    cp0_cause_input                   = 32'h0;
    cp0_epc_input                     = 32'h0;
    wb_cp0_write_enable_input         = 1'b0;
    wb_cp0_write_address_input        = 5'd0;
    wb_cp0_data_input                 = 32'h0;
  endtask

  // Bubbles for a few cycles so the FSM drains back to IDLE.
  task automatic settle();
    clear_inputs();
    repeat (3) step();
  endtask

  task automatic set_interrupt();
    cp0_status_input                  = 32'h0000_0401;
    cp0_cause_input                   = 32'h0000_0400;
    current_instruction_address_input = 32'h100;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset                             = 1'b1;
    interrupt_raw_input               = 6'h3f;
    exception_flags_input             = 32'h100;
    current_instruction_address_input = 32'h100;
    cp0_epc_input                     = 32'h444;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (interrupt_sync_output !== 6'h0 || exception_type_output !== 32'h0 ||
          flush_output !== 1'b0 || new_pc_output !== 32'h0 || epc_effective_output !== 32'h0) begin
        errors++;
        $display("FAIL reset_outputs cyc%0d: sync=%h type=%h flush=%b pc=%h epc=%h, want all 0",
                 i, interrupt_sync_output, exception_type_output, flush_output,
                 new_pc_output, epc_effective_output);
      end
    end
    reset = 1'b0;
    exception_flags_input             = 32'h0;
    current_instruction_address_input = 32'h0;
    step();
    checks++;
    if (interrupt_sync_output !== 6'h0) begin
      errors++;
      $display("FAIL sync_edge1: got %h want 00", interrupt_sync_output);
    end
    step();
    checks++;
    if (interrupt_sync_output !== 6'h3f) begin
      errors++;
      $display("FAIL sync_edge2: got %h want 3f", interrupt_sync_output);
    end
    interrupt_raw_input = 6'h0;
    step();
    step();
    timer_interrupt_input = 1'b1;
    #1;
    checks++;
    if (interrupt_sync_output !== 6'h20) begin
      errors++;
      $display("FAIL timer_or: got %h want 20", interrupt_sync_output);
    end
    timer_interrupt_input = 1'b0;
  endtask

  task automatic test_interrupt_hold();
    settle();
    set_interrupt();
    #1;
    checks++;
    if (exception_type_output !== 32'h1 || flush_output !== 1'b1 || new_pc_output !== 32'h20) begin
      errors++;
      $display("FAIL int_take: type=%h flush=%b pc=%h want 1/1/00000020",
               exception_type_output, flush_output, new_pc_output);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (exception_type_output !== 32'h0 || flush_output !== 1'b0) begin
        errors++;
        $display("FAIL int_masked cyc%0d: type=%h flush=%b want 0/0", i,
                 exception_type_output, flush_output);
      end
    end
    step();
    checks++;
    if (exception_type_output !== 32'h1) begin
      errors++;
      $display("FAIL int_retake: type=%h want 1", exception_type_output);
    end
  endtask

  task automatic test_sync_flags();
    logic [31:0] flag_vec [4];
    logic [31:0] type_vec [4];
    settle();
    exception_flags_input             = 32'h0000_0900;
    current_instruction_address_input = 32'h200;
    cp0_epc_input                     = 32'h0000_0abc;
    #1;
    checks++;
    if (exception_type_output !== 32'h8 || new_pc_output !== 32'h20) begin
      errors++;
      $display("FAIL syscall_ovf: type=%h pc=%h want 8/00000020",
               exception_type_output, new_pc_output);
    end
    flag_vec = '{32'h800, 32'h200, 32'h400, 32'h1000};
    type_vec = '{32'hc,   32'ha,   32'hd,   32'he};
    for (int i = 0; i < 4; i++) begin
      step();
      exception_flags_input = flag_vec[i];
      #1;
      checks++;
      if (exception_type_output !== type_vec[i] || flush_output !== 1'b1 ||
          new_pc_output !== ((type_vec[i] == 32'he) ? 32'habc : 32'h20)) begin
        errors++;
        $display("FAIL flag_vec%0d: type=%h flush=%b pc=%h want type %h", i,
                 exception_type_output, flush_output, new_pc_output, type_vec[i]);
      end
    end
  endtask

  task automatic test_eret_bypass();
    settle();
    exception_flags_input             = 32'h1000;
    current_instruction_address_input = 32'h200;
    cp0_epc_input                     = 32'h400;
    wb_cp0_write_enable_input         = 1'b1;
    wb_cp0_write_address_input        = 5'd14;
    wb_cp0_data_input                 = 32'h500;
    #1;
    checks++;
    if (exception_type_output !== 32'he || new_pc_output !== 32'h500 ||
        epc_effective_output !== 32'h500) begin
      errors++;
      $display("FAIL eret_wb: type=%h pc=%h epc=%h want e/500/500",
               exception_type_output, new_pc_output, epc_effective_output);
    end
    wb_cp0_write_enable_input = 1'b0;
    #1;
    checks++;
    if (new_pc_output !== 32'h400 || epc_effective_output !== 32'h400) begin
      errors++;
      $display("FAIL eret_nowb: pc=%h epc=%h want 400/400", new_pc_output, epc_effective_output);
    end
  endtask

  task automatic test_status_cause_bypass();
    settle();
    set_interrupt();
    wb_cp0_write_enable_input  = 1'b1;
    wb_cp0_write_address_input = 5'd12;
    wb_cp0_data_input          = 32'h0000_0403;
    #1;
    checks++;
    if (exception_type_output !== 32'h0 || flush_output !== 1'b0) begin
      errors++;
      $display("FAIL exl_bypass: type=%h flush=%b want 0/0", exception_type_output, flush_output);
    end
    // Cause bypass forwards only bits 9:8/22/23; bit 10 must stay from CP0.
    cp0_cause_input            = 32'h0;
    wb_cp0_write_address_input = 5'd13;
    wb_cp0_data_input          = 32'h0000_0400;
    #1;
    checks++;
    if (exception_type_output !== 32'h0) begin
      errors++;
      $display("FAIL cause_mask: type=%h want 0", exception_type_output);
    end
    cp0_status_input  = 32'h0000_0101;
    wb_cp0_data_input = 32'h0000_0100;
    #1;
    checks++;
    if (exception_type_output !== 32'h1 || flush_output !== 1'b1) begin
      errors++;
      $display("FAIL cause_ip0: type=%h flush=%b want 1/1", exception_type_output, flush_output);
    end
    settle();
    exception_flags_input = 32'h200;
    #1;
    checks++;
    if (exception_type_output !== 32'h0 || flush_output !== 1'b0) begin
      errors++;
      $display("FAIL bubble: type=%h flush=%b want 0/0", exception_type_output, flush_output);
    end
  endtask

  task automatic test_hold_reload_and_reset();
    settle();
    set_interrupt();
    #1;
    checks++;
    if (exception_type_output !== 32'h1) begin
      errors++;
      $display("FAIL reload_int: type=%h want 1", exception_type_output);
    end
    step();
    exception_flags_input             = 32'h400;
    current_instruction_address_input = 32'h300;
    #1;
    checks++;
    if (exception_type_output !== 32'hd || flush_output !== 1'b1 || new_pc_output !== 32'h20) begin
      errors++;
      $display("FAIL hold_trap: type=%h flush=%b pc=%h want d/1/00000020",
               exception_type_output, flush_output, new_pc_output);
    end
    step();
    exception_flags_input = 32'h0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (exception_type_output !== 32'h0) begin
        errors++;
        $display("FAIL reload_mask cyc%0d: type=%h want 0", i, exception_type_output);
      end
      step();
    end
    checks++;
    if (exception_type_output !== 32'h1) begin
      errors++;
      $display("FAIL reload_exit: type=%h want 1", exception_type_output);
    end
    step();
    checks++;
    if (exception_type_output !== 32'h0) begin
      errors++;
      $display("FAIL hold_again: type=%h want 0", exception_type_output);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (exception_type_output !== 32'h0 || flush_output !== 1'b0 || new_pc_output !== 32'h0) begin
      errors++;
      $display("FAIL reset_force: type=%h flush=%b pc=%h want 0", exception_type_output,
               flush_output, new_pc_output);
    end
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (exception_type_output !== 32'h1 || flush_output !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_hold: type=%h flush=%b want 1/1", exception_type_output, flush_output);
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    test_reset();
    test_interrupt_hold();
    test_sync_flags();
    test_eret_bypass();
    test_status_cause_bypass();
    test_hold_reload_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
